// File: rtl/tensor_operand_dispatch.sv
// Operand dispatcher for one tensor PE lane: latches a micro-op and streams NUM_STEPS beats.
// Optional perf counters are enabled with the TENSOR_DISPATCH_PERF_EN macro.
module tensor_operand_dispatch #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_STEPS = 4,
  parameter int XLEN      = 32,
  localparam int WIDW     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int SW       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int RDW      = $clog2(XLEN)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WIDW-1:0]           req_wid,
  input  logic [RDW-1:0]            req_rd,
  input  logic [1:0]                req_acc_src,
  input  logic                      req_wb,
  input  logic [NUM_STEPS*XLEN-1:0] req_a,
  input  logic [NUM_STEPS*XLEN-1:0] req_b,
  input  logic [NUM_STEPS*XLEN-1:0] req_c,
  input  logic                      flush,
  output logic                      pe_valid,
  input  logic                      pe_ready,
  output logic [XLEN-1:0]           pe_a,
  output logic [XLEN-1:0]           pe_b,
  output logic [XLEN-1:0]           pe_c,
  output logic [1:0]                pe_acc_src,
  output logic                      pe_wb,
  output logic [WIDW-1:0]           pe_wid,
  output logic [RDW-1:0]            pe_rd,
  output logic                      done,
  output logic                      busy
`ifdef TENSOR_DISPATCH_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_ops
`endif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [1:0]    ACC_SRC_TILE = 2'd2;
  localparam logic [SW-1:0] LAST_STEP    = SW'(NUM_STEPS - 1);

  state_t                         state_q, state_d;
  logic [SW-1:0]                  step_q, step_d;
  logic [WIDW-1:0]                wid_q, wid_d;
  logic [RDW-1:0]                 rd_q, rd_d;
  logic [1:0]                     acc_q, acc_d;
  logic                           wb_q, wb_d;
  logic [NUM_STEPS-1:0][XLEN-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                           done_q, done_d;
  logic                           busy_q, busy_d;
  logic                           is_last, beat, accept;

  always_comb begin
    is_last   = (step_q == LAST_STEP);
    beat      = (state_q == ISSUE) && pe_ready;
    req_ready = !flush && ((state_q == IDLE) || (beat && is_last));
    accept    = req_valid && req_ready;

    state_d = state_q;
    step_d  = step_q;
    wid_d   = wid_q;
    rd_d    = rd_q;
    acc_d   = acc_q;
    wb_d    = wb_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = IDLE;
      step_d  = '0;
    end else begin
      if (beat) begin
        if (is_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      // A new accept overrides the return to IDLE, giving zero-bubble back-to-back ops.
      if (accept) begin
        state_d = ISSUE;
        step_d  = '0;
        wid_d   = req_wid;
        rd_d    = req_rd;
        acc_d   = req_acc_src;
        wb_d    = req_wb;
        a_d     = req_a;
        b_d     = req_b;
        c_d     = req_c;
      end
    end
    busy_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      wid_q   <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      wb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      wid_q   <= wid_d;
      rd_q    <= rd_d;
      acc_q   <= acc_d;
      wb_q    <= wb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign pe_valid   = (state_q == ISSUE);
  assign pe_a       = a_q[step_q];
  assign pe_b       = b_q[step_q];
  assign pe_c       = c_q[step_q];
  assign pe_acc_src = (step_q == '0) ? acc_q : ACC_SRC_TILE;
  assign pe_wb      = wb_q && is_last;
  assign pe_wid     = wid_q;
  assign pe_rd      = rd_q;
  assign done       = done_q;
  assign busy       = busy_q;

`ifdef TENSOR_DISPATCH_PERF_EN
  logic [31:0] stall_q, stall_d, ops_q, ops_d;

  // Saturating counters; flush deliberately leaves them untouched.
  always_comb begin
    stall_d = stall_q;
    ops_d   = ops_q;
    if (pe_valid && !pe_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (done_d && (ops_q != '1)) ops_d = ops_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      ops_q   <= '0;
    end else begin
      stall_q <= stall_d;
      ops_q   <= ops_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_ops          = ops_q;
`endif

endmodule

// File: tb/tb_tensor_operand_dispatch.sv
// Self-checking bench for tensor_operand_dispatch: directed scenarios plus a randomized run against a cycle model.
module tb_tensor_operand_dispatch;
  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready, req_wb, flush, pe_valid, pe_ready, pe_wb, done, busy;
  logic [1:0]   req_wid, req_acc_src, pe_acc_src, pe_wid;
  logic [4:0]   req_rd, pe_rd;
  logic [127:0] req_a, req_b, req_c;
  logic [31:0]  pe_a, pe_b, pe_c;

  logic         s1_req_valid, s1_req_ready, s1_req_wb, s1_flush, s1_pe_valid, s1_pe_ready, s1_pe_wb, s1_done, s1_busy;
  logic [1:0]   s1_req_wid, s1_req_acc_src, s1_pe_acc_src, s1_pe_wid;
  logic [4:0]   s1_req_rd, s1_pe_rd;
  logic [31:0]  s1_req_a, s1_req_b, s1_req_c, s1_pe_a, s1_pe_b, s1_pe_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tensor_operand_dispatch #(.NUM_WARPS(4), .NUM_STEPS(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_rd(req_rd), .req_acc_src(req_acc_src), .req_wb(req_wb), .req_a(req_a), .req_b(req_b),
    .req_c(req_c), .flush(flush), .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_a(pe_a),
    .pe_b(pe_b), .pe_c(pe_c), .pe_acc_src(pe_acc_src), .pe_wb(pe_wb), .pe_wid(pe_wid),
    .pe_rd(pe_rd), .done(done), .busy(busy)
  );

  tensor_operand_dispatch #(.NUM_WARPS(4), .NUM_STEPS(1), .XLEN(32)) dut_s1 (
    .clk(clk), .reset(reset), .req_valid(s1_req_valid), .req_ready(s1_req_ready), .req_wid(s1_req_wid),
    .req_rd(s1_req_rd), .req_acc_src(s1_req_acc_src), .req_wb(s1_req_wb), .req_a(s1_req_a),
    .req_b(s1_req_b), .req_c(s1_req_c), .flush(s1_flush), .pe_valid(s1_pe_valid),
    .pe_ready(s1_pe_ready), .pe_a(s1_pe_a), .pe_b(s1_pe_b), .pe_c(s1_pe_c),
    .pe_acc_src(s1_pe_acc_src), .pe_wb(s1_pe_wb), .pe_wid(s1_pe_wid), .pe_rd(s1_pe_rd),
    .done(s1_done), .busy(s1_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] wid, input logic [4:0] rd, input logic [1:0] acc,
                         input logic wb, input logic [31:0] base);
    req_wid = wid; req_rd = rd; req_acc_src = acc; req_wb = wb;
    for (int k = 0; k < 4; k++) begin
      req_a[k*32 +: 32] = base + 32'(k);
      req_b[k*32 +: 32] = $urandom;
      req_c[k*32 +: 32] = $urandom;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (pe_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || pe_a !== 32'd0 || pe_rd !== 5'd0) begin
      failures++;
      $display("FAIL reset got valid=%b done=%b busy=%b ready=%b a=%h rd=%0d exp 0 0 0 1 0 0",
               pe_valid, done, busy, req_ready, pe_a, pe_rd);
    end
  endtask

  task automatic test_basic();
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd2, 5'd5, 2'd0, 1'b1, 32'h10);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", req_ready); end
    tick(); req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pe_valid !== 1'b1 || pe_a !== 32'h10 + 32'(k) || pe_acc_src !== (k == 0 ? 2'd0 : 2'd2) ||
          pe_wb !== (k == 3) || pe_rd !== 5'd5 || pe_wid !== 2'd2 || done !== 1'b0) begin
        failures++;
        $display("FAIL basic_beat%0d got v=%b a=%h acc=%0d wb=%b rd=%0d wid=%0d done=%b exp a=%h",
                 k, pe_valid, pe_a, pe_acc_src, pe_wb, pe_rd, pe_wid, done, 32'h10 + 32'(k));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || pe_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_done got done=%b valid=%b busy=%b exp 1 0 0", done, pe_valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_stall();
    bit [5:0] rdy = 6'b111001;
    int stp[6] = '{0, 1, 1, 1, 2, 3};
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd1, 5'd7, 2'd0, 1'b1, 32'h20);
    tick(); req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      pe_ready = rdy[c];
      #1;
      checks++;
      if (pe_valid !== 1'b1 || pe_a !== 32'h20 + 32'(stp[c]) || done !== 1'b0 || pe_wb !== (stp[c] == 3)) begin
        failures++;
        $display("FAIL stall_cyc%0d got v=%b a=%h done=%b wb=%b exp a=%h", c + 1, pe_valid, pe_a, done, pe_wb,
                 32'h20 + 32'(stp[c]));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL stall_done got=%b exp=1", done); end
    pe_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int ndone = 0;
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd0, 5'd1, 2'd0, 1'b1, 32'h30);
    tick();
    set_req(2'd3, 5'd2, 2'd1, 1'b0, 32'h40);
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (req_ready !== (c == 4) || pe_valid !== 1'b1 || pe_a !== 32'h30 + 32'(c - 1)) begin
        failures++;
        $display("FAIL b2b_first_cyc%0d got ready=%b v=%b a=%h exp ready=%b a=%h", c, req_ready, pe_valid, pe_a,
                 c == 4, 32'h30 + 32'(c - 1));
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    req_valid = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      checks++;
      if (pe_valid !== 1'b1 || pe_a !== 32'h40 + 32'(c - 5) || pe_wid !== 2'd3 ||
          pe_acc_src !== (c == 5 ? 2'd1 : 2'd2) || done !== (c == 5)) begin
        failures++;
        $display("FAIL b2b_second_cyc%0d got v=%b a=%h wid=%0d acc=%0d done=%b exp a=%h", c, pe_valid, pe_a,
                 pe_wid, pe_acc_src, done, 32'h40 + 32'(c - 5));
      end
      if (done === 1'b1) ndone++;
      tick();
    end
    if (done === 1'b1) ndone++;
    checks++;
    if (ndone !== 2 || pe_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_done_count got=%0d valid=%b exp 2 0", ndone, pe_valid);
    end
    tick();
  endtask

  task automatic test_reg_nowb();
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd1, 5'd3, 2'd1, 1'b0, 32'h60);
    tick(); req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (pe_acc_src !== (k == 0 ? 2'd1 : 2'd2) || pe_wb !== 1'b0 || pe_rd !== 5'd3 || pe_a !== 32'h60 + 32'(k)) begin
        failures++;
        $display("FAIL regnowb_beat%0d got acc=%0d wb=%b rd=%0d a=%h exp acc=%0d wb=0 rd=3", k, pe_acc_src,
                 pe_wb, pe_rd, pe_a, k == 0 ? 1 : 2);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL regnowb_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_flush();
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd0, 5'd6, 2'd0, 1'b1, 32'h70);
    tick(); req_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1; req_valid = 1'b1; set_req(2'd1, 5'd8, 2'd0, 1'b1, 32'h80);
    #1;
    checks++;
    if (req_ready !== 1'b0 || pe_a !== 32'h72) begin
      failures++; $display("FAIL flush_ready got ready=%b a=%h exp 0 72", req_ready, pe_a);
    end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if (pe_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_after got v=%b done=%b busy=%b ready=%b exp 0 0 0 1", pe_valid, done, busy, req_ready);
    end
    req_valid = 1'b1; set_req(2'd2, 5'd4, 2'd2, 1'b1, 32'h90);
    tick(); req_valid = 1'b0;
    checks++;
    if (pe_valid !== 1'b1 || pe_a !== 32'h90 || pe_acc_src !== 2'd2 || done !== 1'b0) begin
      failures++;
      $display("FAIL flush_restart got v=%b a=%h acc=%0d done=%b exp 1 90 2 0", pe_valid, pe_a, pe_acc_src, done);
    end
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL flush_restart_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_single_step();
    s1_req_valid = 1'b1; s1_pe_ready = 1'b1; s1_req_acc_src = 2'd0; s1_req_wb = 1'b1;
    s1_req_a = 32'hAB; s1_req_rd = 5'd9; s1_req_wid = 2'd1;
    #1;
    checks++;
    if (s1_req_ready !== 1'b1) begin failures++; $display("FAIL s1_ready got=%b exp=1", s1_req_ready); end
    tick(); s1_req_valid = 1'b0;
    checks++;
    if (s1_pe_valid !== 1'b1 || s1_pe_acc_src !== 2'd0 || s1_pe_wb !== 1'b1 || s1_pe_a !== 32'hAB || s1_pe_rd !== 5'd9) begin
      failures++;
      $display("FAIL s1_beat got v=%b acc=%0d wb=%b a=%h rd=%0d exp 1 0 1 ab 9", s1_pe_valid, s1_pe_acc_src,
               s1_pe_wb, s1_pe_a, s1_pe_rd);
    end
    tick();
    checks++;
    if (s1_done !== 1'b1 || s1_pe_valid !== 1'b0) begin
      failures++; $display("FAIL s1_done got done=%b v=%b exp 1 0", s1_done, s1_pe_valid);
    end
  endtask

  task automatic test_async_reset();
    req_valid = 1'b1; pe_ready = 1'b1; set_req(2'd3, 5'd11, 2'd1, 1'b1, 32'hA0);
    tick(); req_valid = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pe_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || pe_a !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got v=%b done=%b busy=%b ready=%b a=%h exp 0 0 0 1 0", pe_valid, done, busy,
               req_ready, pe_a);
    end
    @(negedge clk) reset = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || pe_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset_after got done=%b v=%b exp 0 0", done, pe_valid);
    end
  endtask

  task automatic test_random();
    logic        m_busy, m_done, e_ready;
    int          m_step;
    logic [1:0]  m_wid, m_acc;
    logic [4:0]  m_rd;
    logic        m_wb;
    logic [31:0] m_a[4], m_b[4], m_c[4];
    m_busy = 1'b0; m_done = 1'b0; m_step = 0;
    m_wid = '0; m_acc = '0; m_rd = '0; m_wb = 1'b0;
    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom % 3) != 0;
      pe_ready = ($urandom % 4) != 0;
      flush = ($urandom % 16) == 0;
      req_wid = 2'($urandom); req_rd = 5'($urandom); req_acc_src = 2'($urandom_range(2)); req_wb = 1'($urandom);
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      req_c = {$urandom, $urandom, $urandom, $urandom};
      #1;
      e_ready = !flush && (!m_busy || (pe_ready && m_step == 3));
      checks++;
      if (req_ready !== e_ready || pe_valid !== m_busy || done !== m_done || busy !== m_busy) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d got ready=%b v=%b done=%b busy=%b exp %b %b %b %b", n, req_ready,
                 pe_valid, done, busy, e_ready, m_busy, m_done, m_busy);
      end
      if (m_busy) begin
        checks++;
        if (pe_a !== m_a[m_step] || pe_b !== m_b[m_step] || pe_c !== m_c[m_step] ||
            pe_acc_src !== (m_step == 0 ? m_acc : 2'd2) || pe_wb !== (m_wb && m_step == 3) ||
            pe_rd !== m_rd || pe_wid !== m_wid) begin
          failures++;
          $display("FAIL rand_data cyc=%0d step=%0d got a=%h acc=%0d wb=%b rd=%0d wid=%0d exp a=%h acc=%0d wb=%b rd=%0d wid=%0d",
                   n, m_step, pe_a, pe_acc_src, pe_wb, pe_rd, pe_wid, m_a[m_step],
                   m_step == 0 ? m_acc : 2'd2, m_wb && m_step == 3, m_rd, m_wid);
        end
      end
      @(posedge clk);
      m_done = 1'b0;
      if (flush) begin
        m_busy = 1'b0; m_step = 0;
      end else begin
        if (m_busy && pe_ready) begin
          if (m_step == 3) begin m_done = 1'b1; m_busy = 1'b0; end
          else m_step++;
        end
        if (req_valid && e_ready) begin
          m_busy = 1'b1; m_step = 0;
          m_wid = req_wid; m_rd = req_rd; m_acc = req_acc_src; m_wb = req_wb;
          for (int k = 0; k < 4; k++) begin
            m_a[k] = req_a[k*32 +: 32]; m_b[k] = req_b[k*32 +: 32]; m_c[k] = req_c[k*32 +: 32];
          end
        end
      end
      #1;
    end
    flush = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wid = '0; req_rd = '0; req_acc_src = '0; req_wb = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; flush = 1'b0; pe_ready = 1'b0;
    s1_req_valid = 1'b0; s1_req_wid = '0; s1_req_rd = '0; s1_req_acc_src = '0; s1_req_wb = 1'b0;
    s1_req_a = '0; s1_req_b = '0; s1_req_c = '0; s1_flush = 1'b0; s1_pe_ready = 1'b0;
    #3;
    test_reset();
    @(negedge clk) reset = 1'b0;
    tick();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reg_nowb();
    test_flush();
    test_single_step();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
